// File: rtl/program_counter.sv
// Fetch-stage program counter: registered fetch address with aligned-load enable,
// sequential-address output and misaligned-load pulse. Define PC_TRACE_EN for prev_pc/load_count.
module program_counter #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      ALIGN_BITS   = 2,
   parameter int unsigned      INC          = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic             misalign
`ifdef PC_TRACE_EN
   ,
   output logic [WIDTH-1:0] prev_pc,
   output logic [31:0]      load_count
`endif
);

   // A zero mask turns the alignment check off, so every load is accepted.
   localparam logic [WIDTH-1:0] ALIGN_MASK =
      (ALIGN_BITS == 0) ? '0 : ~({WIDTH{1'b1}} << ALIGN_BITS);

   function automatic logic is_aligned(input logic [WIDTH-1:0] addr);
      return (addr & ALIGN_MASK) == '0;
   endfunction

   function automatic logic [WIDTH-1:0] add_inc(input logic [WIDTH-1:0] addr);
      return addr + WIDTH'(INC);
   endfunction

   logic load_ok;
   logic load_bad;

   // pc_write gates next_pc first so an unknown next_pc cannot reach pc while holding.
   always_comb begin
      load_ok  = 1'b0;
      load_bad = 1'b0;
      if (pc_write) begin
         load_ok  = is_aligned(next_pc);
         load_bad = ~is_aligned(next_pc);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_VECTOR;
         misalign <= 1'b0;
      end else begin
         if (load_ok)
            pc <= next_pc;
         misalign <= load_bad;
      end
   end

   assign pc_plus_inc = add_inc(pc);

`ifdef PC_TRACE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_pc    <= RESET_VECTOR;
         load_count <= '0;
      end else if (load_ok) begin
         prev_pc <= pc;
         if (load_count != 32'hFFFF_FFFF)
            load_count <= load_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default parameters).
// Trace outputs are checked when PC_TRACE_EN is defined.
module tb_program_counter;

   logic        clk;
   logic        reset;
   logic        pc_write;
   logic [31:0] next_pc;
   logic [31:0] pc;
   logic [31:0] pc_plus_inc;
   logic        misalign;
`ifdef PC_TRACE_EN
   logic [31:0] prev_pc;
   logic [31:0] load_count;
`endif

   int errors = 0;
   int checks = 0;

   program_counter dut (
      .clk         (clk),
      .reset       (reset),
      .pc_write    (pc_write),
      .next_pc     (next_pc),
      .pc          (pc),
      .pc_plus_inc (pc_plus_inc),
      .misalign    (misalign)
`ifdef PC_TRACE_EN
      ,
      .prev_pc     (prev_pc),
      .load_count  (load_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      reset    = 1'b0;
      pc_write = 1'b0;
      next_pc  = 32'h0;
      #10;
      chk("reset_pc", pc, 32'h0000_0000);
      chk("reset_pinc", pc_plus_inc, 32'h0000_0004);
      chk("reset_misalign", {31'b0, misalign}, 32'h0);

      // Sequential loads
      @(negedge clk);
      reset    = 1'b1;
      pc_write = 1'b1;
      next_pc  = 32'h0000_0004;
      edge_step();
      chk("load1_pc", pc, 32'h0000_0004);
      chk("load1_pinc", pc_plus_inc, 32'h0000_0008);
      chk("load1_misalign", {31'b0, misalign}, 32'h0);
      next_pc = 32'h0000_0008;
      edge_step();
      chk("load2_pc", pc, 32'h0000_0008);
      chk("load2_pinc", pc_plus_inc, 32'h0000_000C);

      // Hold, including an unknown next_pc
      pc_write = 1'b0;
      next_pc  = 32'h0000_0010;
      for (int i = 0; i < 3; i++) begin
         edge_step();
         chk("hold_pc", pc, 32'h0000_0008);
      end
      next_pc = 'x;
      edge_step();
      chk("hold_x_pc", pc, 32'h0000_0008);
      pc_write = 1'b1;
      next_pc  = 32'h0000_0020;
      edge_step();
      chk("load3_pc", pc, 32'h0000_0020);

      // Misaligned load is rejected with a one-cycle pulse
      next_pc = 32'h0000_0022;
      edge_step();
      chk("misal_pc", pc, 32'h0000_0020);
      chk("misal_flag", {31'b0, misalign}, 32'h1);
      next_pc = 32'h0000_0040;
      edge_step();
      chk("after_misal_pc", pc, 32'h0000_0040);
      chk("after_misal_flag", {31'b0, misalign}, 32'h0);

      // Wrap of pc_plus_inc
      next_pc = 32'hFFFF_FFFC;
      edge_step();
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pinc", pc_plus_inc, 32'h0000_0000);

      // Mid-cycle async reset with a pending load and a live misalign pulse
      next_pc = 32'h0000_0102;
      edge_step();
      chk("pre_rst_misal", {31'b0, misalign}, 32'h1);
      next_pc = 32'h0000_0100;
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_pc", pc, 32'h0000_0000);
      chk("async_rst_misal", {31'b0, misalign}, 32'h0);
      edge_step();
      chk("rst_noload_pc", pc, 32'h0000_0000);
      @(negedge clk);
      reset = 1'b1;
      edge_step();
      chk("first_load_pc", pc, 32'h0000_0100);
      edge_step();
      chk("same_load_pc", pc, 32'h0000_0100);
      chk("same_load_misal", {31'b0, misalign}, 32'h0);

`ifdef PC_TRACE_EN
      // Trace registers: 3 accepted, 1 rejected, 2 held
      @(negedge clk);
      reset    = 1'b0;
      pc_write = 1'b0;
      #1;
      chk("trace_rst_prev", prev_pc, 32'h0000_0000);
      chk("trace_rst_count", load_count, 32'h0);
      @(negedge clk);
      reset    = 1'b1;
      pc_write = 1'b1;
      next_pc  = 32'h0000_0010;
      edge_step();
      next_pc = 32'h0000_0020;
      edge_step();
      next_pc = 32'h0000_0031;
      edge_step();
      pc_write = 1'b0;
      edge_step();
      edge_step();
      chk("trace_mid_count", load_count, 32'd2);
      pc_write = 1'b1;
      next_pc  = 32'h0000_0030;
      edge_step();
      pc_write = 1'b0;
      chk("trace_pc", pc, 32'h0000_0030);
      chk("trace_count", load_count, 32'd3);
      chk("trace_prev", prev_pc, 32'h0000_0020);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
